// File: rtl/quad_decoder_counter_if.sv
// Encoder and counter signal bundle for quad_decoder_counter.
//   master: drives the encoder phases (qa, qb), load/data and clr_err;
//           observes count, dir, step, err and err_sticky.
//   slave:  the decoder/counter side, the mirror of master.
interface quad_decoder_counter_if #(
    parameter int unsigned WIDTH = 16
);
    logic             qa;
    logic             qb;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             clr_err;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             err;
    logic             err_sticky;

    modport master (
        output qa, qb, load, data, clr_err,
        input  count, dir, step, err, err_sticky
    );

    modport slave (
        input  qa, qb, load, data, clr_err,
        output count, dir, step, err, err_sticky
    );
endinterface

// File: rtl/quad_decoder_counter.sv
// Quadrature (A/B) decoder with 4x decoding driving a loadable up/down position counter.
// Ports:
//   clk  - system clock, all state on posedge
//   rst  - asynchronous active-low reset
//   bus  - slave side of quad_decoder_counter_if:
//          qa, qb      encoder phases (asynchronous to clk)
//          load, data  synchronous load of the position counter
//          clr_err     synchronous clear of err_sticky
//          count       current position (modulo 2^WIDTH)
//          dir         direction of last legal step (1 = up)
//          step        one-cycle pulse per legal step
//          err         one-cycle pulse per illegal (double-bit) transition
//          err_sticky  latched error flag
module quad_decoder_counter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                  clk,
    input logic                  rst,
    quad_decoder_counter_if.slave bus
);

    localparam int unsigned PrimeW = $clog2(SYNC_STAGES + 1);
    localparam logic [PrimeW-1:0] PrimeLast = PrimeW'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_a_q;
    logic [SYNC_STAGES-1:0] sync_b_q;
    logic [1:0]             ab_s;
    logic [1:0]             prev_ab_q;
    logic [1:0]             ab_diff;
    logic [PrimeW-1:0]      prime_cnt_q;
    logic                   primed_q;

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             step_q;
    logic             err_q;
    logic             err_sticky_q, err_sticky_d;

    logic step_ev;
    logic err_ev;
    logic up_ev;

    assign ab_s    = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
    assign ab_diff = prev_ab_q ^ ab_s;

    // Gray-code decode: a single-bit change is a step, a double-bit change is an error.
    // For a single-bit change, old A xor new B is 1 exactly on the forward sequence.
    always_comb begin
        step_ev = primed_q && ((ab_diff == 2'b01) || (ab_diff == 2'b10));
        err_ev  = primed_q && (ab_diff == 2'b11);
        up_ev   = prev_ab_q[1] ^ ab_s[0];
    end

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        if (step_ev) begin
            dir_d   = up_ev;
            count_d = up_ev ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
        // Load wins over a same-cycle step; dir still follows the step.
        if (bus.load) begin
            count_d = bus.data;
        end

        err_sticky_d = err_sticky_q;
        if (bus.clr_err) begin
            err_sticky_d = 1'b0;
        end
        // Set wins whether clr_err coincides with detection or with the visible err pulse.
        if (err_ev || err_q) begin
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a_q     <= '0;
            sync_b_q     <= '0;
            prev_ab_q    <= 2'b00;
            prime_cnt_q  <= '0;
            primed_q     <= 1'b0;
            count_q      <= '0;
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            sync_a_q  <= {sync_a_q[SYNC_STAGES-2:0], bus.qa};
            sync_b_q  <= {sync_b_q[SYNC_STAGES-2:0], bus.qb};
            prev_ab_q <= ab_s;
            // Hold off decoding until prev_ab reflects the levels present at reset release.
            if (!primed_q) begin
                if (prime_cnt_q == PrimeLast) begin
                    primed_q <= 1'b1;
                end else begin
                    prime_cnt_q <= prime_cnt_q + PrimeW'(1);
                end
            end
            count_q      <= count_d;
            dir_q        <= dir_d;
            step_q       <= step_ev;
            err_q        <= err_ev;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.dir        = dir_q;
    assign bus.step       = step_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Self-checking bench for quad_decoder_counter: scoreboard of expected step/err events
// produced by a phase-index encoder model, checked by an independent monitor.
module tb_quad_decoder_counter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SS    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quad_decoder_counter_if #(.WIDTH(WIDTH)) bus ();

    quad_decoder_counter #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic             is_err;
        logic [WIDTH-1:0] count;
        logic             dir;
        logic             sticky;
        logic [31:0]      due;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Encoder model: position in the 4-state cycle plus expected counter state.
    int phase;
    logic [WIDTH-1:0] m_count;
    logic m_dir;
    logic m_sticky;

    function automatic logic [1:0] level(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // kind: +1 forward, -1 reverse, 2 illegal jump. Level held for 'hold' cycles.
    task automatic move(input int kind, input int hold);
        exp_t e;
        @(negedge clk);
        phase = (phase + kind + 4) % 4;
        {bus.qa, bus.qb} = level(phase);
        if (kind == 2) begin
            m_sticky = 1'b1;
            e.is_err = 1'b1;
        end else begin
            e.is_err = 1'b0;
            m_dir    = (kind == 1);
            m_count  = (kind == 1) ? m_count + WIDTH'(1) : m_count - WIDTH'(1);
        end
        e.count  = m_count;
        e.dir    = m_dir;
        e.sticky = m_sticky;
        e.due    = cyc + 1 + SS;
        sb.push_back(e);
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic quiet();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] d);
        @(negedge clk);
        bus.load = 1'b1;
        bus.data = d;
        @(negedge clk);
        bus.load = 1'b0;
        m_count  = d;
        check("load_count", 32'(bus.count), 32'(d));
    endtask

    task automatic lone_clear();
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        m_sticky = 1'b0;
        check("clr_sticky", 32'(bus.err_sticky), 32'd0);
    endtask

    task automatic reset_mid();
        move(2, 4);
        move(1, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_count", 32'(bus.count), 32'd0);
        check("rst_mid_sticky", 32'(bus.err_sticky), 32'd0);
        check("rst_mid_step", 32'(bus.step), 32'd0);
        sb.delete();
        m_count  = '0;
        m_dir    = 1'b0;
        m_sticky = 1'b0;
        phase    = 2;
        {bus.qa, bus.qb} = level(phase);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reprime_step", 32'(bus.step), 32'd0);
            check("reprime_err", 32'(bus.err), 32'd0);
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every step/err pulse must match the oldest expected event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && (bus.step || bus.err)) begin
                check("step_err_exclusive", 32'(bus.step & bus.err), 32'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: step=%0b err=%0b count=%0h, expected no event (t=%0t)",
                             bus.step, bus.err, bus.count, $time);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", 32'(bus.err), 32'(e.is_err));
                    check("event_count", 32'(bus.count), 32'(e.count));
                    check("event_dir", 32'(bus.dir), 32'(e.dir));
                    check("event_sticky", 32'(bus.err_sticky), 32'(e.sticky));
                    check("event_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected completion before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        int kind;
        rst         = 1'b0;
        bus.qa      = 1'b1;
        bus.qb      = 1'b1;
        bus.load    = 1'b0;
        bus.data    = '0;
        bus.clr_err = 1'b0;
        phase       = 2;
        m_count     = '0;
        m_dir       = 1'b0;
        m_sticky    = 1'b0;

        // Reset and priming with both phases high.
        repeat (3) @(negedge clk);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_dir", 32'(bus.dir), 32'd0);
        check("rst_step", 32'(bus.step), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_sticky", 32'(bus.err_sticky), 32'd0);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("prime_step", 32'(bus.step), 32'd0);
            check("prime_err", 32'(bus.err), 32'd0);
            check("prime_count", 32'(bus.count), 32'd0);
        end
        repeat (3) @(negedge clk);

        // Walk 11 -> 10 -> 00, then zero the counter.
        move(1, 3);
        move(1, 3);
        quiet();
        do_load('0);

        // Forward full cycle.
        for (int i = 0; i < 4; i++) move(1, 4);
        quiet();
        check("fwd_count", 32'(bus.count), 32'd4);
        check("fwd_dir", 32'(bus.dir), 32'd1);

        // Reverse through zero.
        do_load('0);
        for (int i = 0; i < 3; i++) move(-1, 4);
        quiet();
        check("rev_count", 32'(bus.count), 32'hFFFD);
        check("rev_dir", 32'(bus.dir), 32'd0);

        // Wrap all-ones forward.
        do_load(16'hFFFF);
        move(1, 4);
        quiet();
        check("wrap_count", 32'(bus.count), 32'd0);

        // Back to 00, then illegal 00 -> 11.
        move(1, 3);
        move(1, 3);
        quiet();
        move(2, 4);
        quiet();
        check("illegal_sticky", 32'(bus.err_sticky), 32'd1);
        check("illegal_count", 32'(bus.count), 32'(m_count));

        // clr_err overlapping an error: set wins.
        move(2, 1);
        @(negedge clk);
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.clr_err = 1'b0;
        quiet();
        check("clr_vs_err_sticky", 32'(bus.err_sticky), 32'd1);
        lone_clear();

        // Load coinciding with a decoded forward step.
        do_load(16'h0010);
        move(1, 1);
        sb[sb.size() - 1].count = 16'h0100;
        m_count = 16'h0100;
        @(negedge clk);
        @(negedge clk);
        bus.load = 1'b1;
        bus.data = 16'h0100;
        @(negedge clk);
        bus.load = 1'b0;
        quiet();
        check("collide_count", 32'(bus.count), 32'h0100);
        check("collide_dir", 32'(bus.dir), 32'd1);

        // Randomized stepping with occasional errors, loads, clears and a mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 250) reset_mid();
            if (i % 80 == 79) begin
                quiet();
                do_load(16'($urandom));
                if ($urandom_range(0, 1) == 1) lone_clear();
            end
            r = int'($urandom_range(0, 9));
            kind = (r < 5) ? 1 : ((r < 9) ? -1 : 2);
            move(kind, int'($urandom_range(1, 4)));
        end
        quiet();
        check("final_count", 32'(bus.count), 32'(m_count));
        check("final_sticky", 32'(bus.err_sticky), 32'(m_sticky));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/quad_decoder_counter.md
Name: quad_decoder_counter

Overview:
- Quadrature (A/B) decoder feeding a loadable up/down position counter.
- Converts raw encoder phase inputs into the step and direction events that drive the team's synchronous up/down counters, so the counter sits on the receiving end of an incremental-encoder interface.
- Uses 4x decoding: every legal edge on A or B moves the count by one.
- Synchronizes the asynchronous A/B inputs and flags illegal (double-bit) transitions.

Parameters:
- WIDTH, 16, width of count and data.
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- qa  input  1  encoder phase A; asynchronous to clk.
- qb  input  1  encoder phase B; asynchronous to clk.
- load  input  1  synchronous load of data into count.
- data  input  WIDTH  load value.
- clr_err  input  1  synchronous clear of err_sticky.
- count  output  WIDTH  current position.
- dir  output  1  direction of the last legal step: 1 = up, 0 = down.
- step  output  1  one-cycle pulse on each legal step.
- err  output  1  one-cycle pulse on each illegal transition.
- err_sticky  output  1  latched error flag.

Behaviour:
- Reset:
  - Clock is clk; reset is asynchronous and active-low on rst. rst=0 immediately forces all state to its reset value, independent of clk.
  - While rst=0 (and on exit): count=0, dir=0, step=0, err=0, err_sticky=0, all synchronizer flops=0, prev_ab=00, priming counter=0, primed=0.
- Synchronizer: qa and qb each pass through SYNC_STAGES flops; the output pair is ab_s = {a_s, b_s}.
- Priming:
  - After rst deasserts, the first SYNC_STAGES+1 posedges only capture prev_ab <= ab_s.
  - During priming: no step, no err, count changes only via load.
  - After priming, primed=1. This prevents a spurious step/err from the input levels present at reset release.
- Decode (primed=1), comparing prev_ab with ab_s each cycle; prev_ab <= ab_s every cycle:
  - No change: no event.
  - Forward sequence 00->01->11->10->00: step=1, dir<=1, count <= count+1.
  - Reverse sequence 00->10->11->01->00: step=1, dir<=0, count <= count-1.
  - Both bits change (00<->11, 01<->10): err=1, err_sticky<=1, count and dir unchanged, no step.
- Arithmetic: count is modulo 2^WIDTH.
  - All-ones + 1 -> 0.
  - 0 - 1 -> all-ones.
  - No saturation, no carry output.
- Latency: an A/B edge first sampled at posedge N is counted at posedge N+SYNC_STAGES, so step and count are visible after posedge N+SYNC_STAGES (3rd posedge for default).
- Load:
  - load=1 sets count <= data on the next posedge.
  - Load has priority over a step in the same cycle: that step is discarded from count, but step and dir still update.
  - Load is allowed during priming.
- err_sticky:
  - Set by any err pulse.
  - Cleared by clr_err=1 at a posedge.
  - If err and clr_err occur in the same cycle, set wins (err_sticky=1).
- step and err are mutually exclusive and each lasts exactly one cycle.
- Reset mid-operation: asserting rst=0 at any time aborts immediately to reset values; priming restarts after release.
- Throughput: one legal step per clk is accepted. Input edges closer together than the synchronizer resolves appear as double-bit changes and are reported as err.

Test Plan:
- Reset and priming: hold qa=1, qb=1 through reset, then release -> no step or err in the first 3 cycles; count=0, primed=1.
- Forward count: from 00, drive 01,11,10,00 with each level held 4 cycles -> 4 step pulses, dir=1, count=4; each step is 3 posedges after its input change.
- Reverse and wrap: from count=0, drive 10,11,01 -> count=0xFFFD, dir=0. Then load data=0xFFFF and drive one forward step -> count=0x0000.
- Illegal transition: from 00, jump qa=qb=1 in one cycle -> err pulse, err_sticky=1, count unchanged. Then assert clr_err and err simultaneously -> err_sticky stays 1; a later clr_err alone clears it to 0.
- Load versus step collision: with count=0x0010, assert load with data=0x0100 in the same cycle a forward step is decoded -> count=0x0100, step=1, dir=1.
- Asynchronous reset mid-stream: assert rst=0 between clk edges during stepping -> count=0, err_sticky=0 immediately. After release, re-priming takes 3 cycles before any step is reported.
